// File: rtl/yuv_wr_sched_pkg.sv
// Shared types for the YUV write scheduler: FSM encoding, plane select, burst sizing.
// No logic; imported by the scheduler top and the per-plane address generator.
package yuv_wr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam logic PLANE_Y  = 1'b0;
  localparam logic PLANE_UV = 1'b1;

  function automatic int unsigned burst_bytes(input int unsigned beats, input int unsigned data_width);
    return beats * data_width / 8;
  endfunction

endpackage

// File: rtl/yuv_wr_sched_if.sv
// Bundle between the two FWFT pixel FIFOs, the scheduler and the DDR write adapter.
// master: the scheduler side; slave: FIFOs plus memory adapter.
interface yuv_wr_sched_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 10
) ();

  logic                  frame_start_i;
  logic [CNT_WIDTH-1:0]  y_cnt_i;
  logic [DATA_WIDTH-1:0] y_data_i;
  logic                  y_rd_en_o;
  logic [CNT_WIDTH-1:0]  uv_cnt_i;
  logic [DATA_WIDTH-1:0] uv_data_i;
  logic                  uv_rd_en_o;
  logic                  cmd_valid_o;
  logic                  cmd_ready_i;
  logic [ADDR_WIDTH-1:0] cmd_addr_o;
  logic [7:0]            cmd_len_o;
  logic                  wr_valid_o;
  logic                  wr_ready_i;
  logic [DATA_WIDTH-1:0] wr_data_o;
  logic                  wr_last_o;
  logic                  resp_i;
  logic [1:0]            frame_idx_o;
  logic                  frame_done_o;
  logic                  ovf_o;

  modport master (
    input  frame_start_i, y_cnt_i, y_data_i, uv_cnt_i, uv_data_i,
           cmd_ready_i, wr_ready_i, resp_i,
    output y_rd_en_o, uv_rd_en_o, cmd_valid_o, cmd_addr_o, cmd_len_o,
           wr_valid_o, wr_data_o, wr_last_o, frame_idx_o, frame_done_o, ovf_o
  );

  modport slave (
    output frame_start_i, y_cnt_i, y_data_i, uv_cnt_i, uv_data_i,
           cmd_ready_i, wr_ready_i, resp_i,
    input  y_rd_en_o, uv_rd_en_o, cmd_valid_o, cmd_addr_o, cmd_len_o,
           wr_valid_o, wr_data_o, wr_last_o, frame_idx_o, frame_done_o, ovf_o
  );

endinterface

// File: rtl/yuv_plane_addr_gen.sv
// Per-plane write offset inside the current frame buffer, with wrap and sticky overflow.
// addr_o is combinational from registered state; offset moves one cycle after adv_i/clr_i.
module yuv_plane_addr_gen
  import yuv_wr_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int BURST_LEN  = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter logic [ADDR_WIDTH-1:0] FRAME_STRIDE = 32'h0040_0000,
  parameter logic [ADDR_WIDTH-1:0] PLANE_OFFSET = '0,
  parameter logic [ADDR_WIDTH-1:0] PLANE_BYTES  = 32'h001F_A400
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  adv_i,
  input  logic [1:0]            frame_idx_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  ovf_o
);

  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(burst_bytes(BURST_LEN, DATA_WIDTH));

  logic [ADDR_WIDTH-1:0] offset_q, offset_d, offset_inc;
  logic                  ovf_q, ovf_d;

  always_comb begin
    offset_inc = offset_q + BURST_BYTES;
    offset_d   = offset_q;
    ovf_d      = ovf_q;
    if (clr_i) begin
      offset_d = '0;
    end else if (adv_i) begin
      if (offset_inc >= PLANE_BYTES) begin
        offset_d = '0;
        ovf_d    = 1'b1;
      end else begin
        offset_d = offset_inc;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      offset_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      offset_q <= offset_d;
      ovf_q    <= ovf_d;
    end
  end

  assign addr_o = BASE_ADDR + ADDR_WIDTH'(frame_idx_i) * FRAME_STRIDE + PLANE_OFFSET + offset_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/yuv_wr_sched.sv
// Round-robin burst writer sharing one memory port between the Y and UV FIFOs; optional stats via YUV_WR_SCHED_STATS_EN.
// Latency: command one cycle after eligibility, first beat one cycle after command accept.
// Backpressure: cmd_ready_i holds the command, wr_ready_i stalls beats (pops only on accepted beats).
module yuv_wr_sched
  import yuv_wr_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 10,
  parameter int BURST_LEN  = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter logic [ADDR_WIDTH-1:0] FRAME_STRIDE   = 32'h0040_0000,
  parameter logic [ADDR_WIDTH-1:0] UV_OFFSET      = 32'h0020_0000,
  parameter logic [ADDR_WIDTH-1:0] Y_PLANE_BYTES  = 32'h001F_A400,
  parameter logic [ADDR_WIDTH-1:0] UV_PLANE_BYTES = 32'h000F_D200,
  parameter int NUM_FRAMES = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  yuv_wr_sched_if.master bus
`ifdef YUV_WR_SCHED_STATS_EN
  ,
  output logic [15:0]  y_bursts_o,
  output logic [15:0]  uv_bursts_o,
  output logic [31:0]  stall_cycles_o
`endif
);

  localparam logic [CNT_WIDTH:0] BURST_CNT  = (CNT_WIDTH+1)'(BURST_LEN);
  localparam logic [7:0]         LAST_BEAT  = 8'(BURST_LEN - 1);
  localparam logic [1:0]         LAST_FRAME = 2'(NUM_FRAMES - 1);

  state_e                state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  rr_q, rr_d;
  logic                  pend_q, pend_d;
  logic [1:0]            frame_idx_q, frame_idx_d;
  logic                  frame_done_q, frame_done_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [7:0]            beat_q, beat_d;

  logic                  y_elig, uv_elig, sel, switch_frame, y_adv, uv_adv, beat_acc;
  logic                  y_ovf, uv_ovf;
  logic [ADDR_WIDTH-1:0] y_addr, uv_addr;

  yuv_plane_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .BURST_LEN(BURST_LEN),
    .BASE_ADDR(BASE_ADDR), .FRAME_STRIDE(FRAME_STRIDE),
    .PLANE_OFFSET('0), .PLANE_BYTES(Y_PLANE_BYTES)
  ) u_y_addr (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(switch_frame), .adv_i(y_adv),
    .frame_idx_i(frame_idx_q), .addr_o(y_addr), .ovf_o(y_ovf)
  );

  yuv_plane_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .BURST_LEN(BURST_LEN),
    .BASE_ADDR(BASE_ADDR), .FRAME_STRIDE(FRAME_STRIDE),
    .PLANE_OFFSET(UV_OFFSET), .PLANE_BYTES(UV_PLANE_BYTES)
  ) u_uv_addr (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(switch_frame), .adv_i(uv_adv),
    .frame_idx_i(frame_idx_q), .addr_o(uv_addr), .ovf_o(uv_ovf)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      grant_q      <= PLANE_Y;
      rr_q         <= PLANE_Y;
      pend_q       <= 1'b0;
      frame_idx_q  <= 2'd0;
      frame_done_q <= 1'b0;
      cmd_addr_q   <= '0;
      beat_q       <= 8'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_q         <= rr_d;
      pend_q       <= pend_d;
      frame_idx_q  <= frame_idx_d;
      frame_done_q <= frame_done_d;
      cmd_addr_q   <= cmd_addr_d;
      beat_q       <= beat_d;
    end
  end

  // rr_q names the plane that wins a tie; a pending frame switch pre-empts arbitration.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_d         = rr_q;
    frame_idx_d  = frame_idx_q;
    cmd_addr_d   = cmd_addr_q;
    beat_d       = beat_q;
    pend_d       = pend_q | bus.frame_start_i;
    switch_frame = 1'b0;
    y_adv        = 1'b0;
    uv_adv       = 1'b0;
    y_elig       = {1'b0, bus.y_cnt_i} >= BURST_CNT;
    uv_elig      = {1'b0, bus.uv_cnt_i} >= BURST_CNT;
    sel          = (y_elig && uv_elig) ? rr_q : (uv_elig ? PLANE_UV : PLANE_Y);
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          switch_frame = 1'b1;
          pend_d       = 1'b0;
          frame_idx_d  = (frame_idx_q == LAST_FRAME) ? 2'd0 : frame_idx_q + 2'd1;
        end else if (y_elig || uv_elig) begin
          grant_d    = sel;
          cmd_addr_d = (sel == PLANE_UV) ? uv_addr : y_addr;
          state_d    = CMD;
        end
      end
      CMD: begin
        if (bus.cmd_ready_i) begin
          state_d = DATA;
          beat_d  = 8'd0;
        end
      end
      DATA: begin
        if (bus.wr_ready_i) begin
          beat_d = beat_q + 8'd1;
          if (beat_q == LAST_BEAT) state_d = RESP;
        end
      end
      RESP: begin
        if (bus.resp_i) begin
          y_adv   = (grant_q == PLANE_Y);
          uv_adv  = (grant_q == PLANE_UV);
          rr_d    = ~grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    frame_done_d = switch_frame;
  end

  always_comb begin
    bus.cmd_valid_o  = (state_q == CMD);
    bus.wr_valid_o   = (state_q == DATA);
    beat_acc         = bus.wr_valid_o && bus.wr_ready_i;
    bus.y_rd_en_o    = beat_acc && (grant_q == PLANE_Y);
    bus.uv_rd_en_o   = beat_acc && (grant_q == PLANE_UV);
    bus.wr_data_o    = (grant_q == PLANE_UV) ? bus.uv_data_i : bus.y_data_i;
    bus.wr_last_o    = bus.wr_valid_o && (beat_q == LAST_BEAT);
    bus.cmd_addr_o   = cmd_addr_q;
    bus.cmd_len_o    = LAST_BEAT;
    bus.frame_idx_o  = frame_idx_q;
    bus.frame_done_o = frame_done_q;
    bus.ovf_o        = y_ovf | uv_ovf;
  end

`ifdef YUV_WR_SCHED_STATS_EN
  logic [15:0] y_cur_q, y_cur_d, uv_cur_q, uv_cur_d;
  logic [15:0] y_bursts_q, y_bursts_d, uv_bursts_q, uv_bursts_d;
  logic [31:0] stall_q, stall_d;

  // Running per-frame counts are published and restarted on every frame switch.
  always_comb begin
    y_cur_d     = y_cur_q + 16'(y_adv);
    uv_cur_d    = uv_cur_q + 16'(uv_adv);
    y_bursts_d  = y_bursts_q;
    uv_bursts_d = uv_bursts_q;
    stall_d     = stall_q;
    if (switch_frame) begin
      y_bursts_d  = y_cur_q;
      uv_bursts_d = uv_cur_q;
      y_cur_d     = 16'd0;
      uv_cur_d    = 16'd0;
    end
    if (bus.wr_valid_o && !bus.wr_ready_i && (stall_q != '1)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      y_cur_q     <= 16'd0;
      uv_cur_q    <= 16'd0;
      y_bursts_q  <= 16'd0;
      uv_bursts_q <= 16'd0;
      stall_q     <= 32'd0;
    end else begin
      y_cur_q     <= y_cur_d;
      uv_cur_q    <= uv_cur_d;
      y_bursts_q  <= y_bursts_d;
      uv_bursts_q <= uv_bursts_d;
      stall_q     <= stall_d;
    end
  end

  assign y_bursts_o     = y_bursts_q;
  assign uv_bursts_o    = uv_bursts_q;
  assign stall_cycles_o = stall_q;
`endif

endmodule

// File: tb/tb_yuv_wr_sched.sv
// Directed bench for yuv_wr_sched: Y-only, alternation, backpressure, frame switch, wrap, mid-burst reset.
// Y plane shrunk to two bursts so the offset wrap shows up quickly.
module tb_yuv_wr_sched;

  localparam int DW = 128;
  localparam int AW = 32;
  localparam int CW = 10;
  localparam int BL = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  yuv_wr_sched_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

`ifdef YUV_WR_SCHED_STATS_EN
  logic [15:0] y_bursts, uv_bursts;
  logic [31:0] stall_cycles;
`endif

  yuv_wr_sched #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .BURST_LEN(BL),
    .Y_PLANE_BYTES(32'h0000_0200)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
`ifdef YUV_WR_SCHED_STATS_EN
    ,
    .y_bursts_o(y_bursts),
    .uv_bursts_o(uv_bursts),
    .stall_cycles_o(stall_cycles)
`endif
  );

  function automatic logic [127:0] word(input logic plane, input int unsigned i);
    return {(plane ? 32'h5A5A_0001 : 32'hA5A5_0000), 64'h0, i};
  endfunction

  // FIFO heads: each pop exposes the next word of a known sequence.
  int unsigned y_ptr = 0;
  int unsigned uv_ptr = 0;
  always @(posedge clk) begin
    if (bus.y_rd_en_o)  y_ptr  <= y_ptr + 1;
    if (bus.uv_rd_en_o) uv_ptr <= uv_ptr + 1;
  end
  assign bus.y_data_i  = word(1'b0, y_ptr);
  assign bus.uv_data_i = word(1'b1, uv_ptr);

  int errs = 0;
  int checks = 0;
  int unsigned exp_y = 0;
  int unsigned exp_uv = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic wait_cmd(input string tag, input logic [31:0] addr);
    int n = 0;
    while (bus.cmd_valid_o !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_cmd_vld"}, 128'(bus.cmd_valid_o), 128'd1);
    chk({tag, "_cmd_addr"}, 128'(bus.cmd_addr_o), 128'(addr));
    chk({tag, "_cmd_len"}, 128'(bus.cmd_len_o), 128'(BL - 1));
    @(negedge clk);
    chk({tag, "_cmd_hold"}, 128'({bus.cmd_valid_o, bus.cmd_addr_o}), 128'({1'b1, addr}));
    bus.cmd_ready_i = 1'b1;
    @(negedge clk);
    bus.cmd_ready_i = 1'b0;
  endtask

  task automatic beats(input string tag, input logic plane, input bit bp, input int n, input int fs_beat);
    int acc = 0;
    int cyc = 0;
    int unsigned p0;
    int unsigned e0;
    logic rdy;
    p0 = plane ? uv_ptr : y_ptr;
    e0 = plane ? exp_uv : exp_y;
    while (acc < n && cyc < 100) begin
      rdy = bp ? (cyc % 2 == 0) : 1'b1;
      bus.wr_ready_i    = rdy;
      bus.frame_start_i = (cyc == fs_beat);
      #1;
      chk({tag, "_wr_vld"}, 128'(bus.wr_valid_o), 128'd1);
      chk({tag, "_pop"}, 128'(plane ? bus.uv_rd_en_o : bus.y_rd_en_o), 128'(rdy));
      chk({tag, "_nopop"}, 128'(plane ? bus.y_rd_en_o : bus.uv_rd_en_o), 128'd0);
      chk({tag, "_dat"}, bus.wr_data_o, word(plane, e0 + unsigned'(acc)));
      chk({tag, "_last"}, 128'(bus.wr_last_o), 128'(acc == BL - 1));
      @(negedge clk);
      if (rdy) acc++;
      cyc++;
    end
    bus.wr_ready_i    = 1'b0;
    bus.frame_start_i = 1'b0;
    chk({tag, "_beats"}, 128'(acc), 128'(n));
    chk({tag, "_pops"}, 128'((plane ? uv_ptr : y_ptr) - p0), 128'(n));
    if (plane) exp_uv += unsigned'(n);
    else       exp_y  += unsigned'(n);
  endtask

  task automatic resp(input string tag, input bit fs);
    chk({tag, "_resp_idle"}, 128'({bus.cmd_valid_o, bus.wr_valid_o}), 128'd0);
    @(negedge clk);
    bus.resp_i        = 1'b1;
    bus.frame_start_i = fs;
    @(negedge clk);
    bus.resp_i        = 1'b0;
    bus.frame_start_i = 1'b0;
  endtask

  task automatic burst(input string tag, input logic [31:0] addr, input logic plane,
                       input bit bp, input int fs_beat, input bit fs_resp);
    wait_cmd(tag, addr);
    beats(tag, plane, bp, BL, fs_beat);
    resp(tag, fs_resp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.frame_start_i = 1'b0;
    bus.y_cnt_i       = '0;
    bus.uv_cnt_i      = '0;
    bus.cmd_ready_i   = 1'b0;
    bus.wr_ready_i    = 1'b0;
    bus.resp_i        = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_vld", 128'(bus.cmd_valid_o), 128'd0);
    chk("rst_wr_vld", 128'(bus.wr_valid_o), 128'd0);
    chk("rst_rd_en", 128'({bus.y_rd_en_o, bus.uv_rd_en_o}), 128'd0);
    chk("rst_addr", 128'(bus.cmd_addr_o), 128'd0);
    chk("rst_len", 128'(bus.cmd_len_o), 128'd15);
    chk("rst_idx", 128'(bus.frame_idx_o), 128'd0);
    chk("rst_flags", 128'({bus.frame_done_o, bus.ovf_o, bus.wr_last_o}), 128'd0);

    // Y-only traffic, then the shrunken Y plane wraps on the third burst.
    rst = 1'b0;
    bus.y_cnt_i = 10'd16;
    burst("y0", 32'h0, 1'b0, 1'b0, -1, 1'b0);
    chk("y0_ovf", 128'(bus.ovf_o), 128'd0);
    burst("y1", 32'h100, 1'b0, 1'b0, -1, 1'b0);
    chk("y1_ovf", 128'(bus.ovf_o), 128'd1);
    // Backpressured wrap burst with a frame start arriving mid-burst.
    burst("y2_wrap", 32'h0, 1'b0, 1'b1, 5, 1'b0);
    @(negedge clk);
    chk("fs_done", 128'(bus.frame_done_o), 128'd1);
    chk("fs_idx", 128'(bus.frame_idx_o), 128'd1);
    chk("fs_ovf_sticky", 128'(bus.ovf_o), 128'd1);
    @(negedge clk);
    chk("fs_done_pulse", 128'(bus.frame_done_o), 128'd0);

    // Reset in the middle of a burst in frame 1.
    wait_cmd("y3", 32'h0040_0000);
    beats("y3", 1'b0, 1'b0, 4, -1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_vld", 128'({bus.cmd_valid_o, bus.wr_valid_o, bus.y_rd_en_o}), 128'd0);
    chk("mrst_idx", 128'(bus.frame_idx_o), 128'd0);
    chk("mrst_ovf", 128'(bus.ovf_o), 128'd0);
    chk("mrst_addr", 128'(bus.cmd_addr_o), 128'd0);

    // Both planes eligible: grants alternate starting with Y.
    bus.uv_cnt_i = 10'd16;
    rst = 1'b0;
    burst("ab_y0", 32'h0, 1'b0, 1'b0, -1, 1'b0);
    burst("ab_uv0", 32'h0020_0000, 1'b1, 1'b0, -1, 1'b0);
    burst("ab_y1", 32'h100, 1'b0, 1'b0, -1, 1'b0);
    burst("ab_uv1", 32'h0020_0100, 1'b1, 1'b0, -1, 1'b1);
    bus.y_cnt_i  = '0;
    bus.uv_cnt_i = '0;
    @(negedge clk);
    chk("sim_done", 128'(bus.frame_done_o), 128'd1);
    chk("sim_idx", 128'(bus.frame_idx_o), 128'd1);
    @(negedge clk);
    chk("sim_quiet", 128'({bus.frame_done_o, bus.cmd_valid_o}), 128'd0);

    // Frame index rotation 1 -> 2 -> 0; a back-to-back pulse collapses into one switch.
    bus.frame_start_i = 1'b1;
    @(negedge clk);
    bus.frame_start_i = 1'b0;
    @(negedge clk);
    chk("rot_idx2", 128'(bus.frame_idx_o), 128'd2);
    chk("rot_done2", 128'(bus.frame_done_o), 128'd1);
    bus.frame_start_i = 1'b1;
    repeat (2) @(negedge clk);
    bus.frame_start_i = 1'b0;
    chk("rot_idx0", 128'(bus.frame_idx_o), 128'd0);
    chk("rot_done0", 128'(bus.frame_done_o), 128'd1);
    @(negedge clk);
    chk("rot_absorb_idx", 128'(bus.frame_idx_o), 128'd0);
    chk("rot_absorb_done", 128'(bus.frame_done_o), 128'd0);

    bus.y_cnt_i = 10'd16;
    burst("f0_y", 32'h0, 1'b0, 1'b0, -1, 1'b0);
    bus.y_cnt_i = '0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
